// File: rtl/pll_supervisor.sv
// pll_supervisor: PLL reset sequencing, lock filtering, staggered clock enables,
// glitch-tolerant loss detection and bounded re-lock retries ending in a latched fault.
module pll_supervisor #(
    parameter int                NumClk            = 4,
    parameter logic [NumClk-1:0] ChanMask          = {NumClk{1'b1}},
    parameter int                ResetCycles       = 16,
    parameter int                LockTimeoutCycles = 65535,
    parameter int                SettleCycles      = 256,
    parameter int                StaggerCycles     = 8,
    parameter int                GlitchCycles      = 2,
    parameter int                MaxRetries        = 3
) (
    input  logic                              ref_clk,
    input  logic                              rst_n,
    input  logic                              restart,
    input  logic                              pll_lock,
    output logic                              pll_rst,
    output logic [NumClk-1:0]                 ch_en,
    output logic                              locked,
    output logic                              fault,
    output logic [$clog2(MaxRetries+1)-1:0]   retry_count,
    output logic                              loss_pulse
);
    localparam int HW = $clog2(ResetCycles + 1);
    localparam int TW = $clog2(LockTimeoutCycles + 1);
    localparam int SW = $clog2(SettleCycles + 1);
    localparam int GW = $clog2(StaggerCycles + 2);
    localparam int LW = $clog2(GlitchCycles + 2);
    localparam int RW = $clog2(MaxRetries + 1);
    localparam logic [HW-1:0] HoldLast = HW'(ResetCycles - 1);
    localparam logic [TW-1:0] TmoLast  = TW'(LockTimeoutCycles - 1);
    localparam logic [SW-1:0] SetLast  = SW'(SettleCycles - 1);
    localparam logic [GW-1:0] StgLast  = GW'((StaggerCycles > 0 ? StaggerCycles : 1) - 1);
    localparam logic [LW-1:0] LowLast  = LW'(GlitchCycles);
    localparam logic [RW-1:0] RetLast  = RW'(MaxRetries - 1);
    localparam logic [RW-1:0] RetMax   = RW'(MaxRetries);

    typedef enum logic [2:0] {RST_HOLD, WAIT_LOCK, SETTLE, ENABLE, RUN, FAULT} state_e;

    state_e            state_q;
    logic [1:0]        sync_q;
    logic [HW-1:0]     hold_q;
    logic [TW-1:0]     tmo_q;
    logic [SW-1:0]     settle_q;
    logic [GW-1:0]     stag_q;
    logic [LW-1:0]     low_q;
    logic [NumClk-1:0] slot_q, slot_d;
    logic [NumClk-1:0] ch_en_q;
    logic [RW-1:0]     retry_q;
    logic              pll_rst_q, locked_q, fault_q, loss_q;
    logic              lock_s, tmo_hit, loss_hit, fail;

    always_comb begin
        lock_s   = sync_q[1];
        slot_d   = slot_q << 1;
        tmo_hit  = (state_q == WAIT_LOCK || state_q == SETTLE) && tmo_q == TmoLast;
        loss_hit = (state_q == ENABLE || state_q == RUN) && !lock_s && low_q == LowLast;
        fail     = tmo_hit || loss_hit;
    end

    always_ff @(posedge ref_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= RST_HOLD;
            sync_q    <= '0;
            hold_q    <= '0;
            tmo_q     <= '0;
            settle_q  <= '0;
            stag_q    <= '0;
            low_q     <= '0;
            slot_q    <= '0;
            ch_en_q   <= '0;
            retry_q   <= '0;
            pll_rst_q <= 1'b1;
            locked_q  <= 1'b0;
            fault_q   <= 1'b0;
            loss_q    <= 1'b0;
        end else begin
            sync_q <= {sync_q[0], pll_lock};
            loss_q <= 1'b0;
            if (restart) begin
                state_q   <= RST_HOLD;
                hold_q    <= '0;
                retry_q   <= '0;
                fault_q   <= 1'b0;
                pll_rst_q <= 1'b1;
                ch_en_q   <= '0;
                locked_q  <= 1'b0;
            end else if (fail) begin
                pll_rst_q <= 1'b1;
                ch_en_q   <= '0;
                locked_q  <= 1'b0;
                hold_q    <= '0;
                loss_q    <= loss_hit;
                if (retry_q >= RetLast) begin
                    state_q <= FAULT;
                    retry_q <= RetMax;
                    fault_q <= 1'b1;
                end else begin
                    state_q <= RST_HOLD;
                    retry_q <= retry_q + 1'b1;
                end
            end else begin
                case (state_q)
                    RST_HOLD: begin
                        if (hold_q == HoldLast) begin
                            state_q   <= WAIT_LOCK;
                            pll_rst_q <= 1'b0;
                            tmo_q     <= '0;
                            settle_q  <= '0;
                        end else hold_q <= hold_q + 1'b1;
                    end
                    WAIT_LOCK: begin
                        tmo_q <= tmo_q + 1'b1;
                        if (lock_s) begin
                            state_q  <= SETTLE;
                            settle_q <= SW'(1);
                        end
                    end
                    SETTLE: begin
                        tmo_q <= tmo_q + 1'b1;
                        if (!lock_s) begin
                            state_q  <= WAIT_LOCK;
                            settle_q <= '0;
                        end else if (settle_q >= SetLast) begin
                            locked_q <= 1'b1;
                            low_q    <= '0;
                            stag_q   <= '0;
                            slot_q   <= NumClk'(1);
                            // With no stagger (or a single channel) every enable goes out at once
                            if (StaggerCycles == 0 || NumClk == 1) begin
                                ch_en_q <= ChanMask;
                                state_q <= RUN;
                            end else begin
                                ch_en_q <= ChanMask & NumClk'(1);
                                state_q <= ENABLE;
                            end
                        end else settle_q <= settle_q + 1'b1;
                    end
                    ENABLE: begin
                        low_q <= lock_s ? '0 : low_q + 1'b1;
                        if (stag_q == StgLast) begin
                            stag_q  <= '0;
                            slot_q  <= slot_d;
                            ch_en_q <= ch_en_q | (ChanMask & slot_d);
                            if (slot_d[NumClk-1]) state_q <= RUN;
                        end else stag_q <= stag_q + 1'b1;
                    end
                    RUN: low_q <= lock_s ? '0 : low_q + 1'b1;
                    default: ;
                endcase
            end
        end
    end

    assign pll_rst     = pll_rst_q;
    assign ch_en       = ch_en_q;
    assign locked      = locked_q;
    assign fault       = fault_q;
    assign retry_count = retry_q;
    assign loss_pulse  = loss_q;
endmodule

// File: tb/tb_pll_supervisor.sv
// tb_pll_supervisor: directed scenarios for pll_supervisor with hand-computed cycle counts.
module tb_pll_supervisor;
    logic       ref_clk = 1'b0;
    logic       rst_n = 1'b0, restart = 1'b0, pll_lock = 1'b0;
    logic       pll_rst, locked, fault, loss_pulse;
    logic [3:0] ch_en;
    logic [1:0] retry_count;
    int         total = 0, passed = 0;

    always #5 ref_clk = ~ref_clk;

    pll_supervisor #(
        .NumClk(4), .ChanMask(4'b1011), .ResetCycles(4), .LockTimeoutCycles(100),
        .SettleCycles(8), .StaggerCycles(3), .GlitchCycles(2), .MaxRetries(2)
    ) dut (
        .ref_clk(ref_clk), .rst_n(rst_n), .restart(restart), .pll_lock(pll_lock),
        .pll_rst(pll_rst), .ch_en(ch_en), .locked(locked), .fault(fault),
        .retry_count(retry_count), .loss_pulse(loss_pulse)
    );

    task automatic tick();
        @(posedge ref_clk);
        #1;
    endtask

    task automatic do_reset(input logic lk);
        rst_n = 1'b0;
        restart = 1'b0;
        pll_lock = lk;
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic wait_pll_rst(input logic v, output int n);
        n = 0;
        while (pll_rst !== v && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic wait_locked(output int n);
        n = 0;
        while (locked !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) tick();
        total++; if (pll_rst !== 1'b1) $display("FAIL reset_pll_rst: got %b want 1", pll_rst); else passed++;
        total++; if (ch_en !== 4'b0000) $display("FAIL reset_ch_en: got %b want 0000", ch_en); else passed++;
        total++; if (locked !== 1'b0) $display("FAIL reset_locked: got %b want 0", locked); else passed++;
        total++; if (fault !== 1'b0) $display("FAIL reset_fault: got %b want 0", fault); else passed++;
        total++; if (retry_count !== 2'd0) $display("FAIL reset_retry: got %0d want 0", retry_count); else passed++;
        total++; if (loss_pulse !== 1'b0) $display("FAIL reset_loss: got %b want 0", loss_pulse); else passed++;
    endtask

    task automatic test_lock();
        int n;
        do_reset(1'b1);
        wait_pll_rst(1'b0, n);
        total++; if (n != 4) $display("FAIL lock_rst_len: got %0d want 4", n); else passed++;
        wait_locked(n);
        total++; if (n != 8) $display("FAIL lock_settle_len: got %0d want 8", n); else passed++;
        total++; if (ch_en !== 4'b0001) $display("FAIL lock_ch_en0: got %b want 0001", ch_en); else passed++;
        repeat (2) tick();
        total++; if (ch_en !== 4'b0001) $display("FAIL lock_ch_en0_hold: got %b want 0001", ch_en); else passed++;
        tick();
        total++; if (ch_en !== 4'b0011) $display("FAIL lock_ch_en1: got %b want 0011", ch_en); else passed++;
        repeat (3) tick();
        total++; if (ch_en !== 4'b0011) $display("FAIL lock_ch_en2: got %b want 0011", ch_en); else passed++;
        repeat (3) tick();
        total++; if (ch_en !== 4'b1011) $display("FAIL lock_ch_en3: got %b want 1011", ch_en); else passed++;
        total++; if (retry_count !== 2'd0) $display("FAIL lock_retry: got %0d want 0", retry_count); else passed++;
    endtask

    task automatic test_glitch_loss();
        int n, m, lp;
        logic bad;
        repeat (3) tick();
        bad = 1'b0;
        pll_lock = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (i == 2) pll_lock = 1'b1;
            tick();
            if (loss_pulse !== 1'b0 || locked !== 1'b1 || ch_en !== 4'b1011) bad = 1'b1;
        end
        total++; if (bad !== 1'b0) $display("FAIL glitch_ignored: got %b want 0", bad); else passed++;
        n = 0;
        pll_lock = 1'b0;
        while (loss_pulse !== 1'b1 && n < 20) begin
            if (n == 3) pll_lock = 1'b1;
            tick();
            n++;
        end
        total++; if (n != 5) $display("FAIL loss_latency: got %0d want 5", n); else passed++;
        total++; if (ch_en !== 4'b0000) $display("FAIL loss_ch_en: got %b want 0000", ch_en); else passed++;
        total++; if (locked !== 1'b0) $display("FAIL loss_locked: got %b want 0", locked); else passed++;
        total++; if (pll_rst !== 1'b1) $display("FAIL loss_pll_rst: got %b want 1", pll_rst); else passed++;
        total++; if (retry_count !== 2'd1) $display("FAIL loss_retry: got %0d want 1", retry_count); else passed++;
        m = 0;
        lp = 0;
        while (pll_rst === 1'b1 && m < 20) begin
            tick();
            m++;
            lp += int'(loss_pulse);
        end
        total++; if (m != 4) $display("FAIL loss_rst_len: got %0d want 4", m); else passed++;
        total++; if (lp != 0) $display("FAIL loss_pulse_width: got %0d extra want 0", lp); else passed++;
    endtask

    task automatic test_timeout_fault();
        int n;
        do_reset(1'b0);
        wait_pll_rst(1'b0, n);
        total++; if (n != 4) $display("FAIL tmo_rst_len: got %0d want 4", n); else passed++;
        wait_pll_rst(1'b1, n);
        total++; if (n != 100) $display("FAIL tmo1_len: got %0d want 100", n); else passed++;
        total++; if (retry_count !== 2'd1) $display("FAIL tmo1_retry: got %0d want 1", retry_count); else passed++;
        total++; if (fault !== 1'b0) $display("FAIL tmo1_fault: got %b want 0", fault); else passed++;
        wait_pll_rst(1'b0, n);
        total++; if (n != 4) $display("FAIL tmo_rst_len2: got %0d want 4", n); else passed++;
        wait_pll_rst(1'b1, n);
        total++; if (n != 100) $display("FAIL tmo2_len: got %0d want 100", n); else passed++;
        total++; if (fault !== 1'b1) $display("FAIL tmo2_fault: got %b want 1", fault); else passed++;
        total++; if (retry_count !== 2'd2) $display("FAIL tmo2_retry: got %0d want 2", retry_count); else passed++;
        pll_lock = 1'b1;
        repeat (20) tick();
        total++; if (fault !== 1'b1) $display("FAIL fault_sticky: got %b want 1", fault); else passed++;
        total++; if (pll_rst !== 1'b1) $display("FAIL fault_pll_rst: got %b want 1", pll_rst); else passed++;
        total++; if (locked !== 1'b0) $display("FAIL fault_locked: got %b want 0", locked); else passed++;
        total++; if (ch_en !== 4'b0000) $display("FAIL fault_ch_en: got %b want 0000", ch_en); else passed++;
    endtask

    task automatic test_restart();
        int n;
        restart = 1'b1;
        tick();
        restart = 1'b0;
        total++; if (fault !== 1'b0) $display("FAIL restart_fault: got %b want 0", fault); else passed++;
        total++; if (retry_count !== 2'd0) $display("FAIL restart_retry: got %0d want 0", retry_count); else passed++;
        total++; if (pll_rst !== 1'b1) $display("FAIL restart_pll_rst: got %b want 1", pll_rst); else passed++;
        wait_pll_rst(1'b0, n);
        total++; if (n != 4) $display("FAIL restart_rst_len: got %0d want 4", n); else passed++;
        wait_locked(n);
        total++; if (n != 8) $display("FAIL restart_settle: got %0d want 8", n); else passed++;
        total++; if (ch_en !== 4'b0001) $display("FAIL restart_ch_en0: got %b want 0001", ch_en); else passed++;
        repeat (9) tick();
        total++; if (ch_en !== 4'b1011) $display("FAIL restart_ch_en_run: got %b want 1011", ch_en); else passed++;
    endtask

    task automatic test_settle_restart();
        int n;
        logic saw_lock;
        do_reset(1'b0);
        wait_pll_rst(1'b0, n);
        pll_lock = 1'b1;
        repeat (5) tick();
        pll_lock = 1'b0;
        repeat (3) tick();
        total++; if (locked !== 1'b0) $display("FAIL settle_drop_locked: got %b want 0", locked); else passed++;
        pll_lock = 1'b1;
        wait_locked(n);
        total++; if (n != 10) $display("FAIL settle_restart_len: got %0d want 10", n); else passed++;
        do_reset(1'b0);
        wait_pll_rst(1'b0, n);
        n = 0;
        saw_lock = 1'b0;
        while (pll_rst !== 1'b1 && n < 200) begin
            pll_lock = (n % 8) < 5;
            tick();
            n++;
            if (locked === 1'b1) saw_lock = 1'b1;
        end
        total++; if (n != 100) $display("FAIL settle_tmo_len: got %0d want 100", n); else passed++;
        total++; if (saw_lock !== 1'b0) $display("FAIL settle_tmo_locked: got %b want 0", saw_lock); else passed++;
        total++; if (retry_count !== 2'd1) $display("FAIL settle_tmo_retry: got %0d want 1", retry_count); else passed++;
    endtask

    task automatic test_async_reset();
        int n;
        do_reset(1'b1);
        wait_pll_rst(1'b0, n);
        wait_locked(n);
        tick();
        total++; if (ch_en !== 4'b0001) $display("FAIL arst_pre_ch_en: got %b want 0001", ch_en); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if (ch_en !== 4'b0000) $display("FAIL arst_ch_en: got %b want 0000", ch_en); else passed++;
        total++; if (pll_rst !== 1'b1) $display("FAIL arst_pll_rst: got %b want 1", pll_rst); else passed++;
        total++; if (locked !== 1'b0) $display("FAIL arst_locked: got %b want 0", locked); else passed++;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_glitch_loss();
        test_timeout_fault();
        test_restart();
        test_settle_restart();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pll_supervisor.md
Name: pll_supervisor

Overview:
- Parametrised PLL control and monitor. Runs in the PLL reference-clock domain, alongside any N-output PLL primitive wrapper.
- Sequences the PLL reset and filters its lock output. Releases per-output clock enables in a staggered order.
- Detects loss of lock with glitch rejection, performs bounded automatic re-lock retries, and latches a fault after repeated failure.
- Top-level clock/reset logic consumes `locked`, `ch_en` and `fault`; the PLL wrapper consumes `pll_rst`.

Parameters:
- NumClk, 4: number of PLL output channels (1..7).
- ChanMask, {NumClk{1'b1}}: bit i=1 means channel i may be enabled; masked channels stay 0 but still consume a stagger slot.
- ResetCycles, 16: pll_rst assertion length per attempt, in cycles (>=1).
- LockTimeoutCycles, 65535: cycles allowed in WAIT_LOCK+SETTLE before a retry (>=SettleCycles+1).
- SettleCycles, 256: consecutive synchronised-lock-high cycles required before enabling outputs (>=1).
- StaggerCycles, 8: cycles between successive ch_en bits; 0 means all bits assert together.
- GlitchCycles, 2: lock-low cycles tolerated in ENABLE/RUN; the (GlitchCycles+1)th consecutive low cycle is a loss.
- MaxRetries, 3: failed attempts (timeouts plus losses) before FAULT (>=1).

Ports:
- `ref_clk`, in, 1: reference clock; the only clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `restart`, in, 1: synchronous 1-cycle request. Clears retry_count and fault; re-enters RST_HOLD.
- `pll_lock`, in, 1: raw PLL LOCK; asynchronous, 2-FF synchronised internally into lock_s.
- `pll_rst`, out, 1: active-high reset to the PLL.
- `ch_en`, out, NumClk: per-channel clock enables.
- `locked`, out, 1: high in ENABLE and RUN.
- `fault`, out, 1: high in FAULT.
- `retry_count`, out, $clog2(MaxRetries+1): failed attempts since reset or restart; saturates at MaxRetries.
- `loss_pulse`, out, 1: 1-cycle pulse on each detected lock loss.

Behaviour:
- All outputs are registered.
- Reset values: pll_rst=1, ch_en=0, locked=0, fault=0, retry_count=0, loss_pulse=0, state=RST_HOLD, counters=0, synchroniser=0.
- Latency: lock_s lags pll_lock by 2 cycles. All decisions use lock_s.
- RST_HOLD: pll_rst=1 for ResetCycles cycles, then go to WAIT_LOCK with pll_rst=0 on the next cycle. The timeout counter clears on entry.
- WAIT_LOCK: the timeout counter increments every cycle.
  - lock_s=1: go to SETTLE, settle counter=1.
  - Timeout counter reaches LockTimeoutCycles: this is a failure (see below).
- SETTLE: the timeout counter keeps running.
  - lock_s=0: return to WAIT_LOCK; the settle counter clears, the timeout counter does not.
  - Settle counter reaches SettleCycles: go to ENABLE.
  - Timeout reached: failure; timeout takes priority over settle completion in the same cycle.
- ENABLE: locked=1.
  - On the entry cycle, ch_en[0]=ChanMask[0].
  - ch_en[i] asserts StaggerCycles cycles after slot i-1.
  - After slot NumClk-1 asserts, go to RUN.
  - If StaggerCycles=0, all bits assert on the entry cycle and the next state is RUN.
- RUN: hold ch_en=ChanMask, locked=1.
- Loss detection (ENABLE and RUN only):
  - The low counter counts consecutive lock_s=0 cycles and clears on lock_s=1.
  - When the count reaches GlitchCycles+1: ch_en=0, locked=0, loss_pulse=1 on the next cycle, then failure handling.
- Failure handling:
  - If retry_count+1 >= MaxRetries: retry_count=MaxRetries, go to FAULT.
  - Otherwise: retry_count++, go to RST_HOLD.
- FAULT: pll_rst=1, ch_en=0, fault=1. Exit only via rst_n or restart.
- Priority: rst_n > restart > failure > normal transition.
  - restart from any state, including mid-hold, restarts RST_HOLD from count 0.
  - restart clears retry_count and fault.
- pll_lock toggling during RST_HOLD or FAULT is ignored.
- Counter widths: $clog2 of the largest counted value +1. No wrap is permitted; counters stop at their terminal value.

Test Plan:
Common parameters: NumClk=4, ChanMask=4'b1011, ResetCycles=4, LockTimeoutCycles=100, SettleCycles=8, StaggerCycles=3, GlitchCycles=2, MaxRetries=2.
1. Release rst_n; pll_lock=1 from the start → pll_rst high 4 cycles. locked=1 in ENABLE after 8 settle cycles. ch_en steps 0001→0011→0011→1011 at 3-cycle intervals. retry_count=0.
2. In RUN, drop pll_lock for 2 cycles → no change. Drop it for 3 cycles → loss_pulse once, ch_en=0, locked=0, pll_rst re-asserts for 4 cycles, retry_count=1.
3. pll_lock held 0 → timeout after 100 cycles, retry_count=1. Second timeout → fault=1, pll_rst=1, retry_count=2. Later pll_lock=1 is ignored.
4. In FAULT, pulse restart → fault=0, retry_count=0, RST_HOLD. Lock then succeeds as in scenario 1.
5. Lock drops after 5 settle cycles, then returns → settle restarts. The timeout counter is not reset, so a timeout occurs at cycle 100 if settle cannot complete.
6. Assert rst_n low asynchronously during ENABLE → immediately ch_en=0, pll_rst=1, locked=0.
